// File: rtl/br_resolve_queue_pkg.sv
// Shared types for the branch resolution queue: widths, compare ops, entry layout.
package br_resolve_queue_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned THREAD_WIDTH = 2;
    localparam int unsigned TAG_WIDTH    = 4;
    localparam int unsigned DEPTH        = 8;
    localparam int unsigned IDX_W        = $clog2(DEPTH);
    localparam int unsigned PTR_W        = IDX_W + 1;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } br_op_e;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DONE   = 2'd2,
        ST_KILLED = 2'd3
    } entry_state_e;

    typedef struct packed {
        br_op_e                  op;
        logic                    is_jalr;
        logic [XLEN-1:0]         pc;
        logic [XLEN-1:0]         offset;
        logic [THREAD_WIDTH-1:0] tid;
        logic [XLEN-1:0]         v1;
        logic [XLEN-1:0]         v2;
        logic                    rdy1;
        logic                    rdy2;
        logic [TAG_WIDTH-1:0]    q1;
        logic [TAG_WIDTH-1:0]    q2;
        logic                    taken;
        logic [XLEN-1:0]         pc_n;
        entry_state_e            state;
    } entry_t;

endpackage

// File: rtl/br_resolve_queue_if.sv
// Issue, CDB, flush and fetch-result signals of the branch resolution queue.
interface br_resolve_queue_if;
    import br_resolve_queue_pkg::*;

    logic                    issue_en;
    logic                    issue_is_jalr;
    logic [2:0]              issue_op;
    logic [XLEN-1:0]         issue_pc;
    logic [XLEN-1:0]         issue_offset;
    logic [THREAD_WIDTH-1:0] issue_thread_id;
    logic [XLEN-1:0]         issue_v1;
    logic [XLEN-1:0]         issue_v2;
    logic                    issue_v1_rdy;
    logic                    issue_v2_rdy;
    logic [TAG_WIDTH-1:0]    issue_q1;
    logic [TAG_WIDTH-1:0]    issue_q2;
    logic                    cdb_valid;
    logic [TAG_WIDTH-1:0]    cdb_tag;
    logic [XLEN-1:0]         cdb_value;
    logic                    flush_en;
    logic [THREAD_WIDTH-1:0] flush_thread_id;
    logic                    res_ack;
    logic                    issue_ready;
    logic                    res_valid;
    logic                    res_taken;
    logic [THREAD_WIDTH-1:0] res_thread_id;
    logic [XLEN-1:0]         res_pc_n;
    logic                    busy;
    logic [PTR_W-1:0]        count;

    modport master (
        output issue_en, issue_is_jalr, issue_op, issue_pc, issue_offset, issue_thread_id,
               issue_v1, issue_v2, issue_v1_rdy, issue_v2_rdy, issue_q1, issue_q2,
               cdb_valid, cdb_tag, cdb_value, flush_en, flush_thread_id, res_ack,
        input  issue_ready, res_valid, res_taken, res_thread_id, res_pc_n, busy, count
    );

    modport slave (
        input  issue_en, issue_is_jalr, issue_op, issue_pc, issue_offset, issue_thread_id,
               issue_v1, issue_v2, issue_v1_rdy, issue_v2_rdy, issue_q1, issue_q2,
               cdb_valid, cdb_tag, cdb_value, flush_en, flush_thread_id, res_ack,
        output issue_ready, res_valid, res_taken, res_thread_id, res_pc_n, busy, count
    );

endinterface

// File: rtl/br_compare.sv
// Shared branch comparator: signed/unsigned condition evaluation for one entry.
module br_compare
    import br_resolve_queue_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  br_op_e          op,
    output logic            taken_c
);

    always_comb begin
        taken_c = 1'b0;
        case (op)
            BR_EQ:   taken_c = (a == b);
            BR_NE:   taken_c = (a != b);
            BR_LT:   taken_c = ($signed(a) <  $signed(b));
            BR_GE:   taken_c = ($signed(a) >= $signed(b));
            BR_LTU:  taken_c = (a <  b);
            BR_GEU:  taken_c = (a >= b);
            default: taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_resolve_queue.sv
// In-order branch resolution queue: CDB snooping, oldest-ready resolve, per-thread flush.
module br_resolve_queue
    import br_resolve_queue_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    br_resolve_queue_if.slave bus
);

    entry_t           entries   [DEPTH];
    entry_t           entries_n [DEPTH];
    logic [PTR_W-1:0] head, tail, head_n, tail_n, count_n;
    logic [IDX_W-1:0] sel, scan_idx, head_idx;
    logic             found, sel_taken_c, flush_hit, accept;
    entry_t           sel_e, new_e, head_e_n;

    assign head_idx = head[IDX_W-1:0];
    assign sel_e    = entries[sel];

    // Oldest WAIT entry with both operands ready, scanning forward from head
    always_comb begin
        found    = 1'b0;
        sel      = head_idx;
        scan_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_idx + IDX_W'(i);
            if (!found && entries[scan_idx].state == ST_WAIT &&
                entries[scan_idx].rdy1 && entries[scan_idx].rdy2) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    br_compare u_compare (
        .a       (sel_e.v1),
        .b       (sel_e.v2),
        .op      (sel_e.op),
        .taken_c (sel_taken_c)
    );

    // New entry with same-cycle CDB bypass; JALR never waits on its second operand
    always_comb begin
        new_e         = '0;
        new_e.op      = br_op_e'(bus.issue_op);
        new_e.is_jalr = bus.issue_is_jalr;
        new_e.pc      = bus.issue_pc;
        new_e.offset  = bus.issue_offset;
        new_e.tid     = bus.issue_thread_id;
        new_e.v1      = bus.issue_v1;
        new_e.v2      = bus.issue_v2;
        new_e.rdy1    = bus.issue_v1_rdy;
        new_e.rdy2    = bus.issue_v2_rdy | bus.issue_is_jalr;
        new_e.q1      = bus.issue_q1;
        new_e.q2      = bus.issue_q2;
        new_e.state   = ST_WAIT;
        if (!new_e.rdy1 && bus.cdb_valid && bus.cdb_tag == bus.issue_q1) begin
            new_e.rdy1 = 1'b1;
            new_e.v1   = bus.cdb_value;
        end
        if (!new_e.rdy2 && bus.cdb_valid && bus.cdb_tag == bus.issue_q2) begin
            new_e.rdy2 = 1'b1;
            new_e.v2   = bus.cdb_value;
        end
    end

    // Next state: wakeup, resolve, flush, pop, allocate (later steps take priority)
    always_comb begin
        entries_n = entries;
        head_n    = head;
        tail_n    = tail;
        flush_hit = bus.flush_en && (bus.issue_thread_id == bus.flush_thread_id);
        accept    = bus.issue_en && bus.issue_ready && !stall_i && !flush_hit;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries[i].state == ST_WAIT && bus.cdb_valid) begin
                if (!entries[i].rdy1 && entries[i].q1 == bus.cdb_tag) begin
                    entries_n[i].v1   = bus.cdb_value;
                    entries_n[i].rdy1 = 1'b1;
                end
                if (!entries[i].rdy2 && entries[i].q2 == bus.cdb_tag) begin
                    entries_n[i].v2   = bus.cdb_value;
                    entries_n[i].rdy2 = 1'b1;
                end
            end
        end

        if (found && !stall_i) begin
            entries_n[sel].state = ST_DONE;
            entries_n[sel].taken = sel_e.is_jalr | sel_taken_c;
            if (sel_e.is_jalr)
                entries_n[sel].pc_n = (sel_e.v1 + sel_e.offset) & ~XLEN'(1);
            else if (sel_taken_c)
                entries_n[sel].pc_n = sel_e.pc + sel_e.offset;
            else
                entries_n[sel].pc_n = sel_e.pc + XLEN'(4);
        end

        if (bus.flush_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entries_n[i].state != ST_FREE && entries_n[i].tid == bus.flush_thread_id)
                    entries_n[i].state = ST_KILLED;
            end
        end

        if (entries[head_idx].state == ST_KILLED ||
            (entries[head_idx].state == ST_DONE && bus.res_ack && !stall_i)) begin
            entries_n[head_idx].state = ST_FREE;
            head_n = head + PTR_W'(1);
        end

        if (accept) begin
            entries_n[tail[IDX_W-1:0]] = new_e;
            tail_n = tail + PTR_W'(1);
        end

        count_n  = tail_n - head_n;
        head_e_n = entries_n[head_n[IDX_W-1:0]];
    end

    // State and registered result/status outputs derived from the next head entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
            head              <= '0;
            tail              <= '0;
            bus.res_valid     <= 1'b0;
            bus.res_taken     <= 1'b0;
            bus.res_thread_id <= '0;
            bus.res_pc_n      <= '0;
            bus.issue_ready   <= 1'b1;
            bus.busy          <= 1'b0;
            bus.count         <= '0;
        end else begin
            entries           <= entries_n;
            head              <= head_n;
            tail              <= tail_n;
            bus.res_valid     <= (head_e_n.state == ST_DONE);
            bus.res_taken     <= (head_e_n.state == ST_DONE) & head_e_n.taken;
            bus.res_thread_id <= (head_e_n.state == ST_DONE) ? head_e_n.tid : '0;
            bus.res_pc_n      <= (head_e_n.state == ST_DONE) ? head_e_n.pc_n : '0;
            bus.issue_ready   <= (count_n < PTR_W'(DEPTH));
            bus.busy          <= (count_n != '0);
            bus.count         <= count_n;
        end
    end

endmodule

// File: doc/br_resolve_queue.md
# br_resolve_queue

Multi-entry, multi-thread branch resolution queue between the issue stage and the fetch PC-select logic. Holds up to DEPTH in-flight conditional branches and JALRs in program order, captures missing operands from the CDB, resolves one ready entry per cycle with a shared comparator, and retires results in order to fetch over a valid/ack handshake. Adds per-thread flush, a correct JALR target, and a parameterised depth and thread count.

## Interface
- XLEN, 32, datapath width
- THREAD_WIDTH, 2, thread-id width
- TAG_WIDTH, 4, CDB/ROB tag width
- DEPTH, 8, queue entries, power of two, at least 2
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- stall_i  in  1  freeze allocation, resolution and pop
- issue_en  in  1  issue request
- issue_is_jalr  in  1  1 = JALR, 0 = conditional branch
- issue_op  in  3  compare op (BR_EQ, NE, LT, GE, LTU, GEU)
- issue_pc, issue_offset  in  XLEN  instruction PC, sign-extended immediate
- issue_thread_id  in  THREAD_WIDTH  owning thread
- issue_v1/issue_v2  in  XLEN  operand values
- issue_v1_rdy/issue_v2_rdy  in  1  operand valid
- issue_q1/issue_q2  in  TAG_WIDTH  producer tag if not ready
- cdb_valid  in  1, cdb_tag  in  TAG_WIDTH, cdb_value  in  XLEN  broadcast bus
- flush_en  in  1, flush_thread_id  in  THREAD_WIDTH  kill all entries of a thread
- res_ack  in  1  fetch consumes result
- issue_ready  out  1  queue can accept (count < DEPTH)
- res_valid  out  1, res_taken  out  1, res_thread_id  out  THREAD_WIDTH, res_pc_n  out  XLEN
- busy  out  1  any entry occupied
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry state: FREE, WAIT (operand missing or not yet resolved), DONE (result stored), KILLED.
- Allocation: issue_en && issue_ready && !stall_i writes entry at tail, tail++. Operands not ready but matching a same-cycle cdb_valid tag are captured as ready (bypass).
- Wakeup: every cycle, including stall, each WAIT entry with an unready operand whose q matches cdb_tag under cdb_valid latches cdb_value and sets rdy.
- Resolution: oldest WAIT entry (by age from head) with both operands ready is resolved through br_compare; result written, state to DONE. One per cycle.
- Next PC, modulo 2^XLEN: branch taken = pc+offset; not taken = pc+4; JALR = (v1+offset) with bit 0 cleared, res_taken=1. v2 ignored for JALR.
- Output: res_valid = head entry DONE. Pop on res_valid && res_ack && !stall_i. KILLED head is popped silently, one per cycle, regardless of res_ack (not stall-gated).
- Flush: flush_en marks every non-FREE entry with matching thread KILLED, same edge; an issue for that thread in that cycle is dropped (not allocated). Not gated by stall_i.
- Pointers are $clog2(DEPTH)+1 bits; full/empty from MSB compare; wrap naturally.
- Reset: all entries FREE, head=tail=0; res_valid=0, res_taken=0, res_thread_id=0, res_pc_n=0, issue_ready=1, busy=0, count=0.

## Timing
- Issue with both operands ready at edge N -> resolve at edge N+1 -> res_valid high after N+1 if at head (2-cycle latency).
- CDB wakeup at edge M -> resolve no earlier than M+1.
- issue_ready depends only on registered count; a same-cycle pop does not free a slot for same-cycle issue.
- Pop at edge P: next head visible after P; back-to-back DONE entries give one result per cycle.
- Result outputs hold stable while res_valid && !res_ack.
- Reset asserted mid-operation clears all state immediately; no result emitted.

## Structure
- Shared package: BR op encodings, entry-state enum, entry struct (op, is_jalr, pc, offset, tid, v1/v2, rdy, q, taken, pc_n, state).
- Sub-module br_compare: combinational (a, b, op) -> taken; signed/unsigned compares.
- Entry array as registers (not RAM) since all entries snoop the CDB in parallel.

## Test plan
- BEQ tid 1, v1=v2=5, pc=0x100, off=0x20 -> res_valid 2 cycles later, taken=1, pc_n=0x120, tid=1.
- BLTU v1 not ready q1=3, v2=7; cdb tag 3 value 9 two cycles later -> not taken, pc_n=pc+4 one cycle after wakeup+1.
- JALR v1=0x1003, off=4 -> taken=1, pc_n=0x1006.
- Fill 8 entries, res_ack=0 -> issue_ready=0, count=8; ack once -> issue_ready=1 next cycle, ninth issue accepted, tail wraps.
- Entries tids 0,2,0,2 queued, flush tid 2 -> only tid 0 results emitted, in order; count returns to 0.
- stall_i high with CDB broadcast -> operand captured, no pop/resolve until stall drops, then result appears.
